// File: rtl/aes_decrypt_core_if.sv
// Handshake and data bus of the AES-128 decrypt core.
//   start        request, sampled only while the core is not busy
//   cipher_text  128-bit ciphertext, [127:96] = word 0
//   key          128-bit cipher key, [127:96] = w0
//   plain_text   128-bit result register
//   finish       high from completion until the next accepted start
//   busy         high while the key is being expanded or rounds are running
interface aes_decrypt_core_if;
  logic         start;
  logic [127:0] cipher_text;
  logic [127:0] key;
  logic [127:0] plain_text;
  logic         finish;
  logic         busy;

  modport master (output start, cipher_text, key,
                  input  plain_text, finish, busy);
  modport slave  (input  start, cipher_text, key,
                  output plain_text, finish, busy);
endinterface

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor, one round per clock.
// A start request first expands the cipher key forward to the round-10 key
// (10 cycles), then runs the inverse cipher for 10 cycles while stepping the
// round key backwards. With KEY_CACHE=1 the last round-10 key is kept and a
// repeated key skips the expansion.
//   clk   rising-edge clock
//   nrst  asynchronous active-low reset
//   bus   aes_decrypt_core_if slave (start/cipher_text/key in,
//         plain_text/finish/busy out)
module aes_decrypt_core #(
  parameter int KEY_CACHE = 1
) (
  input  logic               clk,
  input  logic               nrst,
  aes_decrypt_core_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  state_t       state_q;
  logic [3:0]   cnt_q;
  logic [3:0]   rnd_q;
  logic [127:0] rk_q;
  logic [127:0] st_q;
  logic [127:0] ct_q;
  logic [127:0] pt_q;
  logic [127:0] cache_key_q;
  logic [127:0] cache_rk10_q;
  logic         cache_vld_q;
  logic         finish_q;
  logic         busy_q;

  logic [127:0] fwd_rk_d;
  logic [127:0] pk_d;
  logic [127:0] u_d;
  logic [127:0] imc_d;
  logic         hit_d;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] i;
    i = gf_inv(b);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] n);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_rot_word(k[31:0]) ^ {rcon(n), 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one schedule step: w3..w1 come from neighbouring XORs, w0 needs
  // the recovered previous w3 to rebuild the SubWord/rcon term.
  function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [3:0] n);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rcon(n), 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  // Column-major state: byte index r + 4c sits at [127-8*(r+4c) -: 8].
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = inv_sbox(s[127-8*(w+4*((c-w+4)%4)) -: 8]);
    return r;
  endfunction

  function automatic logic [7:0] imc_mul(input logic [7:0] a, input int sel);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    case (sel)
      0:       return x8 ^ x4 ^ x2;  // 0e
      1:       return x8 ^ x2 ^ a;   // 0b
      2:       return x8 ^ x4 ^ a;   // 0d
      default: return x8 ^ a;        // 09
    endcase
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++)
          b = b ^ imc_mul(s[127-8*(k+4*c) -: 8], (k - w + 4) % 4);
        r[127-8*(w+4*c) -: 8] = b;
      end
    return r;
  endfunction

  always_comb begin
    fwd_rk_d = next_key(rk_q, cnt_q);
    pk_d     = prev_key(rk_q, rnd_q);
    u_d      = inv_sub_shift(st_q) ^ pk_d;
    imc_d    = inv_mix_columns(u_d);
    hit_d    = (KEY_CACHE != 0) && cache_vld_q && (bus.key == cache_key_q);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rnd_q        <= '0;
      rk_q         <= '0;
      st_q         <= '0;
      ct_q         <= '0;
      pt_q         <= '0;
      cache_key_q  <= '0;
      cache_rk10_q <= '0;
      cache_vld_q  <= 1'b0;
      finish_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            ct_q     <= bus.cipher_text;
            finish_q <= 1'b0;
            busy_q   <= 1'b1;
            if (hit_d) begin
              st_q    <= bus.cipher_text ^ cache_rk10_q;
              rk_q    <= cache_rk10_q;
              rnd_q   <= 4'd10;
              state_q <= ROUND;
            end else begin
              // The cache entry is rebuilt for this key; it only becomes
              // valid once the round-10 key has actually been reached.
              rk_q        <= bus.key;
              cnt_q       <= 4'd1;
              cache_key_q <= bus.key;
              cache_vld_q <= 1'b0;
              state_q     <= KEXP;
            end
          end
        end
        KEXP: begin
          rk_q  <= fwd_rk_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd10) begin
            st_q         <= ct_q ^ fwd_rk_d;
            rnd_q        <= 4'd10;
            cache_rk10_q <= fwd_rk_d;
            cache_vld_q  <= 1'b1;
            state_q      <= ROUND;
          end
        end
        ROUND: begin
          rk_q <= pk_d;
          if (rnd_q == 4'd1) begin
            pt_q     <= u_d;
            finish_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end else begin
            st_q  <= imc_d;
            rnd_q <= rnd_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.plain_text = pt_q;
  assign bus.finish     = finish_q;
  assign bus.busy       = busy_q;

endmodule
